// File: rtl/simd_norm_pkg.sv
// ---------------------------------------------------------------------------
// simd_norm_pkg
// Shared definitions for the SIMD layer-norm path: the mean/variance FSM
// state encoding and the 1/sqrt LUT index range together with the variance
// clamp bounds derived from it.
// No ports (package).
// ---------------------------------------------------------------------------
package simd_norm_pkg;

  // Mean/variance stage sequencing.
  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_MEAN  = 2'd1,
    ST_VAR   = 2'd2,
    ST_OUT   = 2'd3
  } norm_state_e;

  // Valid index range of the downstream 1/sqrt LUT (integer part of variance).
  localparam int LUT_IDX_MIN = 1;
  localparam int LUT_IDX_MAX = 63;

  // Default fractional width of the layer-norm fixed-point path.
  localparam int NORM_FRAC_BITS = 8;

  // Smallest variance whose integer field is LUT_IDX_MIN.
  function automatic int varMin(input int fracBits);
    return LUT_IDX_MIN << fracBits;
  endfunction

  // Largest variance whose integer field is still LUT_IDX_MAX.
  function automatic int varMax(input int fracBits);
    return ((LUT_IDX_MAX + 1) << fracBits) - 1;
  endfunction

  localparam int VAR_MIN = varMin(NORM_FRAC_BITS);
  localparam int VAR_MAX = varMax(NORM_FRAC_BITS);

endpackage

// File: rtl/norm_sq_mult.sv
// ---------------------------------------------------------------------------
// norm_sq_mult
// Registered signed squarer shared by the mean/variance stage. The result
// appears one clock after the operand is presented.
// Ports:
//   clk        clock
//   reset      synchronous active-high reset
//   operand_i  signed operand, DATA_WIDTH bits
//   square_o   operand*operand, unsigned, 2*DATA_WIDTH bits
// ---------------------------------------------------------------------------
module norm_sq_mult #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [DATA_WIDTH-1:0]  operand_i,
  output logic [2*DATA_WIDTH-1:0]       square_o
);

  logic signed [2*DATA_WIDTH-1:0] operandExt;
  logic signed [2*DATA_WIDTH-1:0] product;
  logic [2*DATA_WIDTH-1:0]        square_q;

  // Sign-extend before multiplying so the full-width product is exact; a
  // square is never negative, so reinterpreting it as unsigned is safe.
  always_comb begin
    operandExt = {{DATA_WIDTH{operand_i[DATA_WIDTH-1]}}, operand_i};
    product    = operandExt * operandExt;
  end

  // One pipeline register on the product.
  always_ff @(posedge clk) begin
    if (reset) begin
      square_q <= '0;
    end else begin
      square_q <= unsigned'(product);
    end
  end

  assign square_o = square_q;

endmodule

// File: rtl/layernorm_var_accum.sv
// ---------------------------------------------------------------------------
// layernorm_var_accum
// Streaming mean/variance stage of the SIMD layer-norm path, directly ahead
// of the 1/sqrt LUT. Accumulates sum and sum-of-squares over one vector of
// 2**LOG2_N signed samples, then emits mean and variance. The variance is
// clamped so its integer field always indexes the LUT range 1..63.
// Ports:
//   clk        clock
//   reset      synchronous active-high reset
//   in_data    signed sample, Q.FRAC_BITS
//   in_valid   sample valid
//   in_ready   stage accepts a sample
//   var_out    clamped variance, unsigned Q.FRAC_BITS
//   mean_out   mean, signed Q.FRAC_BITS, sign-extended
//   out_valid  result valid
//   out_ready  downstream accepts result
//   sat_lo     variance raised to lower clamp
//   sat_hi     variance lowered to upper clamp
// ---------------------------------------------------------------------------
module layernorm_var_accum
  import simd_norm_pkg::*;
#(
  parameter int BIT_WIDTH  = 32,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int LOG2_N     = 6,
  parameter int EPS        = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [BIT_WIDTH-1:0]         var_out,
  output logic [BIT_WIDTH-1:0]         mean_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         sat_lo,
  output logic                         sat_hi
);

  localparam int SUM_W   = DATA_WIDTH + LOG2_N;
  localparam int SQ_W    = 2 * DATA_WIDTH;
  localparam int SUMSQ_W = SQ_W + LOG2_N;
  // Two extra bits keep ex2 - mean^2 representable as a signed value.
  localparam int V_W     = SQ_W + 2;

  localparam logic [LOG2_N-1:0]    LAST_IDX = '1;
  localparam logic [V_W-1:0]       VAR_MIN_V = V_W'(varMin(FRAC_BITS));
  localparam logic [V_W-1:0]       VAR_MAX_V = V_W'(varMax(FRAC_BITS));
  localparam logic [V_W-1:0]       EPS_V     = V_W'(EPS);

  norm_state_e                  state_q;
  logic                         varPhase_q;
  logic [LOG2_N-1:0]            count_q;
  logic signed [SUM_W-1:0]      sum_q;
  logic [SUMSQ_W-1:0]           sumSq_q;
  logic                         sqPend_q;
  logic signed [DATA_WIDTH-1:0] mean_q;
  logic [SQ_W-1:0]              ex2_q;
  logic                         inReady_q;
  logic                         outValid_q;
  logic [BIT_WIDTH-1:0]         varOut_q;
  logic [BIT_WIDTH-1:0]         meanOut_q;
  logic                         satLo_q;
  logic                         satHi_q;

  logic                         accept;
  logic signed [DATA_WIDTH-1:0] sqOperand;
  logic [SQ_W-1:0]              sqResult;
  logic [SUMSQ_W-1:0]           sumSq_d;
  logic signed [DATA_WIDTH-1:0] mean_d;
  logic [SQ_W-1:0]              ex2_d;
  logic signed [V_W-1:0]        varDiff;
  logic [V_W-1:0]               varNonNeg;
  logic [V_W-1:0]               varEps;
  logic [BIT_WIDTH-1:0]         varOut_d;
  logic                         satLo_d;
  logic                         satHi_d;

  // The squarer is time-shared: it squares incoming samples while
  // accumulating and squares the registered mean during the variance phase.
  always_comb begin
    accept    = (state_q == ST_ACCUM) && in_valid && inReady_q;
    sqOperand = '0;
    case (state_q)
      ST_ACCUM: sqOperand = in_data;
      ST_VAR:   sqOperand = mean_q;
      default:  sqOperand = '0;
    endcase
  end

  norm_sq_mult #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sq_mult (
    .clk       (clk),
    .reset     (reset),
    .operand_i (sqOperand),
    .square_o  (sqResult)
  );

  // A sample's square lands one cycle after the sample is accepted, so the
  // sum-of-squares lags the sum by one cycle; the last square is folded in
  // during the MEAN cycle, which is why ex2 is only taken in VAR.
  always_comb begin
    sumSq_d = sumSq_q;
    if (sqPend_q) begin
      sumSq_d = sumSq_q + SUMSQ_W'(sqResult);
    end
    mean_d = DATA_WIDTH'(sum_q >>> LOG2_N);
    ex2_d  = SQ_W'(sumSq_q >> LOG2_N);
  end

  // Variance from E[x^2] - mean^2, floored at zero, rescaled to Q.FRAC_BITS,
  // biased by EPS and clamped into the LUT's index range.
  always_comb begin
    varDiff   = signed'({2'b00, ex2_q}) - signed'({2'b00, sqResult});
    varNonNeg = varDiff[V_W-1] ? '0 : unsigned'(varDiff);
    varEps    = (varNonNeg >> FRAC_BITS) + EPS_V;
    varOut_d  = BIT_WIDTH'(varEps);
    satLo_d   = 1'b0;
    satHi_d   = 1'b0;
    if (varEps < VAR_MIN_V) begin
      varOut_d = BIT_WIDTH'(VAR_MIN_V);
      satLo_d  = 1'b1;
    end else if (varEps > VAR_MAX_V) begin
      varOut_d = BIT_WIDTH'(VAR_MAX_V);
      satHi_d  = 1'b1;
    end
  end

  // Control FSM with all outputs registered. VAR spends two cycles: the
  // first issues mean to the squarer and captures ex2, the second forms the
  // clamped variance, giving out_valid three edges after the last sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ACCUM;
      varPhase_q <= 1'b0;
      count_q    <= '0;
      sum_q      <= '0;
      sumSq_q    <= '0;
      sqPend_q   <= 1'b0;
      mean_q     <= '0;
      ex2_q      <= '0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      varOut_q   <= '0;
      meanOut_q  <= '0;
      satLo_q    <= 1'b0;
      satHi_q    <= 1'b0;
    end else begin
      sumSq_q  <= sumSq_d;
      sqPend_q <= 1'b0;
      case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            sum_q    <= sum_q + SUM_W'(in_data);
            sqPend_q <= 1'b1;
            count_q  <= count_q + 1'b1;
            if (count_q == LAST_IDX) begin
              state_q   <= ST_MEAN;
              inReady_q <= 1'b0;
            end
          end
        end
        ST_MEAN: begin
          mean_q     <= mean_d;
          varPhase_q <= 1'b0;
          state_q    <= ST_VAR;
        end
        ST_VAR: begin
          if (!varPhase_q) begin
            ex2_q      <= ex2_d;
            varPhase_q <= 1'b1;
          end else begin
            varOut_q   <= varOut_d;
            meanOut_q  <= BIT_WIDTH'(mean_q);
            satLo_q    <= satLo_d;
            satHi_q    <= satHi_d;
            outValid_q <= 1'b1;
            varPhase_q <= 1'b0;
            state_q    <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            sum_q      <= '0;
            sumSq_q    <= '0;
            count_q    <= '0;
            inReady_q  <= 1'b1;
            state_q    <= ST_ACCUM;
          end
        end
        default: begin
          state_q <= ST_ACCUM;
        end
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign var_out   = varOut_q;
  assign mean_out  = meanOut_q;
  assign sat_lo    = satLo_q;
  assign sat_hi    = satHi_q;

endmodule

// File: tb/tb_layernorm_var_accum.sv
// ---------------------------------------------------------------------------
// tb_layernorm_var_accum
// Directed bench for the layer-norm mean/variance stage. A plain-arithmetic
// model predicts each vector's mean/variance; a monitor compares the DUT
// against it every cycle out_valid is high, and the main sequence pins the
// results to hand-computed literals.
// ---------------------------------------------------------------------------
module tb_layernorm_var_accum;

  localparam int N = 64;

  typedef struct {
    longint v;
    longint m;
    bit     lo;
    bit     hi;
  } exp_t;

  logic               clk;
  logic               reset;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        var_out;
  logic [31:0]        mean_out;
  logic               out_valid;
  logic               out_ready;
  logic               sat_lo;
  logic               sat_hi;

  int   nChecks = 0;
  int   nFails  = 0;
  exp_t expQ[$];

  layernorm_var_accum dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .var_out   (var_out),
    .mean_out  (mean_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_lo    (sat_lo),
    .sat_hi    (sat_hi)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never finishes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Floor division by the vector length, correct for negative sums.
  function automatic longint floorDivN(input longint s);
    if (s >= 0) return s / N;
    return -((-s + N - 1) / N);
  endfunction

  // Reference: mean = floor(sum/N), E[x^2] = floor(sumsq/N),
  // var = max(0, E[x^2]-mean^2)/256 clamped to [256, 16383].
  function automatic exp_t modelVector(input int vec[N]);
    exp_t   e;
    longint s  = 0;
    longint ss = 0;
    longint ex2;
    longint v;
    for (int i = 0; i < N; i++) begin
      s  += longint'(vec[i]);
      ss += longint'(vec[i]) * longint'(vec[i]);
    end
    e.m  = floorDivN(s);
    ex2  = ss / N;
    v    = ex2 - e.m * e.m;
    if (v < 0) v = 0;
    v    = v / 256;
    e.lo = 1'b0;
    e.hi = 1'b0;
    if (v < 256) begin
      v    = 256;
      e.lo = 1'b1;
    end else if (v > 16383) begin
      v    = 16383;
      e.hi = 1'b1;
    end
    e.v = v;
    return e;
  endfunction

  function automatic void buildVector(input int pattern, output int vec[N]);
    for (int k = 0; k < N; k++) begin
      case (pattern)
        0:       vec[k] = 256;
        1:       vec[k] = (k % 2 == 0) ? 512 : -512;
        2:       vec[k] = (k % 2 == 0) ? 2048 : -2048;
        default: vec[k] = -2100 + 64 * k + (k % 3);
      endcase
    end
  endfunction

  // Every cycle a result is presented it must match the oldest expectation;
  // it retires when the downstream handshake happens on the next edge.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_out_valid", 1, 0);
      end else begin
        checkOutput("mon_var_out", longint'(var_out), expQ[0].v);
        checkOutput("mon_mean_out", longint'($signed(mean_out)), expQ[0].m);
        checkOutput("mon_sat_lo", longint'(sat_lo), longint'(expQ[0].lo));
        checkOutput("mon_sat_hi", longint'(sat_hi), longint'(expQ[0].hi));
        if (out_ready) void'(expQ.pop_front());
      end
    end
  end

  // Streams one vector (optionally with bubbles), checks latency and that
  // in_ready stays low while busy, and returns the first presented result.
  // Entered and left 1 time unit after a rising edge.
  task automatic applyStimulus(input int vec[N], input bit bubbles,
                               output longint rVar, output longint rMean,
                               output bit rLo, output bit rHi);
    int idx     = 0;
    int guard   = 0;
    int k       = 0;
    bit acc;
    bit sawReady = 1'b0;
    expQ.push_back(modelVector(vec));
    while (idx < N && guard < 2000) begin
      if (bubbles && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = 16'(vec[idx]);
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    if (idx < N) checkOutput("accept_timeout", longint'(idx), N);
    while (!out_valid && k < 20) begin
      if (in_ready) sawReady = 1'b1;
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("latency_edges", longint'(k), 3);
    checkOutput("in_ready_low_while_busy", longint'(sawReady), 0);
    rVar  = longint'(var_out);
    rMean = longint'($signed(mean_out));
    rLo   = sat_lo;
    rHi   = sat_hi;
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int     vec[N];
    longint rVar;
    longint rMean;
    bit     rLo;
    bit     rHi;
    exp_t   e;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state.
    @(negedge clk);
    checkOutput("reset_in_ready", longint'(in_ready), 1);
    checkOutput("reset_out_valid", longint'(out_valid), 0);
    checkOutput("reset_var_out", longint'(var_out), 0);
    checkOutput("reset_mean_out", longint'(mean_out), 0);
    checkOutput("reset_sat", longint'({sat_hi, sat_lo}), 0);
    @(posedge clk);
    #1;

    // Pin the model against hand-computed results.
    buildVector(0, vec);
    e = modelVector(vec);
    checkOutput("model_const_var", e.v, 256);
    checkOutput("model_const_lo", longint'(e.lo), 1);
    buildVector(3, vec);
    e = modelVector(vec);
    checkOutput("model_ramp_mean", e.m, -84);

    // Test 1: constant 1.0 -> zero variance raised to the lower clamp.
    $display("[TB] test 1: constant vector");
    buildVector(0, vec);
    applyStimulus(vec, 1'b0, rVar, rMean, rLo, rHi);
    checkOutput("t1_var", rVar, 256);
    checkOutput("t1_mean", rMean, 256);
    checkOutput("t1_sat_lo", longint'(rLo), 1);
    checkOutput("t1_sat_hi", longint'(rHi), 0);

    // Test 2: +/-2.0 alternating -> variance 4.0.
    $display("[TB] test 2: alternating +/-512");
    buildVector(1, vec);
    applyStimulus(vec, 1'b0, rVar, rMean, rLo, rHi);
    checkOutput("t2_var", rVar, 1024);
    checkOutput("t2_mean", rMean, 0);
    checkOutput("t2_sat", longint'({rHi, rLo}), 0);

    // Test 3: +/-8.0 alternating -> variance 64.0 lowered to the upper clamp.
    $display("[TB] test 3: alternating +/-2048");
    buildVector(2, vec);
    applyStimulus(vec, 1'b0, rVar, rMean, rLo, rHi);
    checkOutput("t3_var", rVar, 16383);
    checkOutput("t3_sat_hi", longint'(rHi), 1);
    checkOutput("t3_sat_lo", longint'(rLo), 0);

    // Ramp with a negative, non-integer mean exercises the floor.
    $display("[TB] ramp vector");
    buildVector(3, vec);
    applyStimulus(vec, 1'b0, rVar, rMean, rLo, rHi);
    checkOutput("ramp_mean", rMean, -84);

    // Test 4: test 2 vector with bubbles.
    $display("[TB] test 4: bubbles");
    buildVector(1, vec);
    applyStimulus(vec, 1'b1, rVar, rMean, rLo, rHi);
    checkOutput("t4_var", rVar, 1024);
    checkOutput("t4_mean", rMean, 0);

    // Test 5: downstream stall, then a vector right after the handshake.
    $display("[TB] test 5: output stall");
    out_ready = 1'b0;
    buildVector(2, vec);
    applyStimulus(vec, 1'b0, rVar, rMean, rLo, rHi);
    for (int c = 0; c < 4; c++) begin
      checkOutput("t5_hold_valid", longint'(out_valid), 1);
      checkOutput("t5_hold_in_ready", longint'(in_ready), 0);
      checkOutput("t5_hold_var", longint'(var_out), rVar);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t5_after_hs_valid", longint'(out_valid), 0);
    checkOutput("t5_after_hs_in_ready", longint'(in_ready), 1);
    buildVector(1, vec);
    applyStimulus(vec, 1'b0, rVar, rMean, rLo, rHi);
    checkOutput("t5_var", rVar, 1024);

    // Test 6: reset part-way through a vector discards the partial sums.
    $display("[TB] test 6: reset mid-vector");
    buildVector(2, vec);
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(vec[i]);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("t6_reset_in_ready", longint'(in_ready), 1);
    checkOutput("t6_reset_out_valid", longint'(out_valid), 0);
    buildVector(1, vec);
    applyStimulus(vec, 1'b0, rVar, rMean, rLo, rHi);
    checkOutput("t6_var", rVar, 1024);
    checkOutput("t6_mean", rMean, 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("pending_results", longint'(expQ.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
